// File: rtl/cla_adder_32b.sv
// rtl/cla_adder_32b.sv - 32-bit two-level carry-lookahead adder with registered sum and carry out
module cla_adder_32b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] result,
  output logic        c_out
);

  // Bit-level propagate and generate terms
  logic [31:0] p;
  logic [31:0] g;

  // Group-level propagate/generate for the eight 4-bit groups
  logic [7:0]  grp_p;
  logic [7:0]  grp_g;

  // Group carry-ins: gc[k] enters group k, gc[8] leaves group 7
  logic [8:0]  gc;

  // Carry into every bit position
  logic [31:0] c;

  // Combinational sum feeding the output register
  logic [31:0] sum;

  assign p = a ^ b;
  assign g = a & b;

  // Group P is the AND of the four bit propagates; group G is the 4-bit lookahead generate
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int k = 0; k < 8; k++) begin
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Second-level lookahead: every group carry is a flat sum of products of
  // group G/P and c_in, so no group waits on its neighbour's carry
  always_comb begin : second_level
    logic pall;
    logic term;
    gc    = '0;
    pall  = 1'b1;
    term  = 1'b0;
    gc[0] = c_in;
    for (int k = 1; k <= 8; k++) begin
      pall = 1'b1;
      term = 1'b0;
      for (int j = k - 1; j >= 0; j--) begin
        term = term | (grp_g[j] & pall);
        pall = pall & grp_p[j];
      end
      gc[k] = term | (pall & c_in);
    end
  end

  // First-level lookahead inside each group, seeded by that group's carry-in
  always_comb begin
    c = '0;
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k]
               | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum = p ^ c;

  // Output register; reset clears it immediately and drops any in-flight sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      c_out  <= 1'b0;
    end else begin
      result <= sum;
      c_out  <= gc[8];
    end
  end

endmodule

// File: tb/tb_cla_adder_32b.sv
// tb/tb_cla_adder_32b.sv - randomized self-checking bench for cla_adder_32b
module tb_cla_adder_32b;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic [31:0] result;
  logic        c_out;

  int checks;
  int errors;

  cla_adder_32b dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .result (result),
    .c_out  (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got {c_out,result}=%h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    longint unsigned s;
    s = longint'(x) + longint'(y) + longint'(ci);
    return s[32:0];
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Apply one operand set at a falling edge and check it one full cycle later
  task automatic single_op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic ci);
    @(negedge clk);
    a    = x;
    b    = y;
    c_in = ci;
    @(negedge clk);
    check(tag, {c_out, result}, model(x, y, ci));
  endtask

  logic [32:0] exp_prev;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    a      = $urandom;
    b      = $urandom;
    c_in   = 1'b1;

    // Asynchronous reset with no clock edge yet
    #2 rst_n = 1'b0;
    #1 check("reset_async", {c_out, result}, 33'd0);

    // Reset holds outputs at zero across clock edges with live inputs
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 32'h1234_5678;
    @(negedge clk);
    check("reset_hold", {c_out, result}, 33'd0);
    rst_n = 1'b1;

    single_op("add_64k",       32'd65536,      32'd65536,      1'b0);
    single_op("msb_msb_cin",   32'h8000_0000,  32'h8000_0000,  1'b1);
    single_op("msb_msb",       32'h8000_0000,  32'h8000_0000,  1'b0);
    single_op("full_chain",    32'hFFFF_FFFF,  32'h0,          1'b1);
    single_op("nibble_carry",  32'h0000_000F,  32'h1,          1'b0);
    single_op("cin_only",      32'h0,          32'h0,          1'b1);
    single_op("ones_ones_cin", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1);
    single_op("group_edge",    32'h0FFF_FFFF,  32'h0000_0001,  1'b0);

    // Back-to-back ops: each output reflects the previous cycle's inputs
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; c_in = 1'b1;
    exp_prev = model(a, b, c_in);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b2b", {c_out, result}, exp_prev);
      a = rand_operand(); b = rand_operand(); c_in = 1'($urandom_range(0, 1));
      exp_prev = model(a, b, c_in);
    end

    // Reset pulse mid-stream: make sure a non-zero sum is already registered
    @(negedge clk);
    check("b2b_last", {c_out, result}, exp_prev);
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; c_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_mid_async", {c_out, result}, 33'd0);
    @(negedge clk);
    check("reset_mid_drop", {c_out, result}, 33'd0);
    rst_n = 1'b1;
    a = 32'h0000_0003; b = 32'h0000_0004; c_in = 1'b1;
    exp_prev = model(a, b, c_in);
    @(negedge clk);
    check("after_reset", {c_out, result}, exp_prev);

    // Random back-to-back stream against the arithmetic model
    a = rand_operand(); b = rand_operand(); c_in = 1'($urandom_range(0, 1));
    exp_prev = model(a, b, c_in);
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      check("random", {c_out, result}, exp_prev);
      a = rand_operand(); b = rand_operand(); c_in = 1'($urandom_range(0, 1));
      exp_prev = model(a, b, c_in);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
